// File: rtl/temp_sampler.sv
// temp_sampler: acquisition front-end for the incubator temperature loop.
// It reads an 8-bit two's-complement temperature from a 3-wire serial sensor
// once per SAMPLE_PERIOD clocks and smooths it with a 4-sample moving
// average. It presents the result as a stable signed byte `t`.
// The sensor fault code 8'h80 is rejected and flagged on `fault`.
//
// Ports
//   clk      system clock (single domain)
//   rst      asynchronous active-low reset
//   sdo      sensor serial data, MSB first, sensor updates it after sclk falls
//   cs_n     sensor chip select, active low (registered)
//   sclk     sensor serial clock, idles low (registered)
//   t        filtered temperature in degC, held between updates
//   t_valid  one-cycle pulse in the cycle `t` is updated
//   fault    set by a fault code, cleared by the next good sample
module temp_sampler #(
  parameter int SAMPLE_PERIOD = 1000,  // >= 17*CLK_DIV + 4
  parameter int CLK_DIV       = 4      // clk cycles per sclk half-period, >= 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              sdo,
  output logic              cs_n,
  output logic              sclk,
  output logic signed [7:0] t,
  output logic              t_valid,
  output logic              fault
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [7:0] FAULT_CODE = 8'h80;

  typedef enum logic [2:0] {IDLE, SETUP, SH_LO, SH_HI, DONE} state_t;

  state_t        state, nstate;
  logic [PW-1:0] per_cnt;
  logic          tick;
  logic [DW-1:0] div_cnt;
  logic          div_end;
  logic          timed;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          cs_n_d, sclk_d, shift_en;

  // Only the three most recent samples are stored. The oldest of the four
  // window entries is always the one discarded by the next good sample, so
  // it never contributes to a sum and needs no storage. win[0] is newest.
  logic [2:0][7:0]   win;
  logic              win_full;
  logic signed [9:0] sum;

  function automatic logic signed [9:0] sx(input logic [7:0] v);
    return {{2{v[7]}}, v};
  endfunction

  // ---------------------------------------------------------------- timer
  assign tick = (per_cnt == PW'(SAMPLE_PERIOD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) per_cnt <= '0;
    else      per_cnt <= tick ? '0 : per_cnt + PW'(1);
  end

  // ------------------------------------------------ sclk half-period divider
  // Runs only in the timed states and restarts at every state boundary.
  assign timed   = (state == SETUP) || (state == SH_LO) || (state == SH_HI);
  assign div_end = (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_cnt <= '0;
    else      div_cnt <= (timed && !div_end) ? div_cnt + DW'(1) : '0;
  end

  // ------------------------------------------------------- FSM: state reg
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  // ------------------------------------------------------ FSM: next state
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (tick)    nstate = SETUP;
      SETUP:   if (div_end) nstate = SH_LO;
      SH_LO:   if (div_end) nstate = SH_HI;
      SH_HI:   if (div_end) nstate = (bit_cnt == 3'd7) ? DONE : SH_LO;
      DONE:                 nstate = IDLE;
      default:              nstate = IDLE;
    endcase
  end

  // ---------------------------------------------------------- FSM: outputs
  // Decoded from the next state so the registered pins line up with the
  // state they belong to (cs_n falls in the first SETUP cycle, and sclk
  // rises on the same edge that enters SH_HI).
  always_comb begin
    cs_n_d   = 1'b1;
    sclk_d   = 1'b0;
    shift_en = (state != SH_HI) && (nstate == SH_HI);
    unique case (nstate)
      SETUP, SH_LO: cs_n_d = 1'b0;
      SH_HI: begin
        cs_n_d = 1'b0;
        sclk_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_n <= 1'b1;
      sclk <= 1'b0;
    end else begin
      cs_n <= cs_n_d;
      sclk <= sclk_d;
    end
  end

  // ------------------------------------------------------- serial capture
  // sdo is sampled at the sclk rising edge. The sensor only moves it after
  // the falling edge, so it has been stable for CLK_DIV cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      if (shift_en) shreg <= {shreg[6:0], sdo};
      if (state == DONE)
        bit_cnt <= '0;
      else if (state == SH_HI && div_end && bit_cnt != 3'd7)
        bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // ------------------------------------------------------ moving average
  // The 10-bit sum of four sign-extended bytes cannot overflow. Taking the
  // top eight bits of the two's-complement sum is an arithmetic shift by 2,
  // which rounds toward minus infinity.
  always_comb sum = sx(shreg) + sx(win[0]) + sx(win[1]) + sx(win[2]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win      <= '0;
      win_full <= 1'b0;
      t        <= '0;
      t_valid  <= 1'b0;
      fault    <= 1'b0;
    end else begin
      t_valid <= 1'b0;
      if (state == DONE) begin
        if (shreg == FAULT_CODE) begin
          fault <= 1'b1;
        end else begin
          fault    <= 1'b0;
          t_valid  <= 1'b1;
          win_full <= 1'b1;
          if (!win_full) begin
            // First good sample primes the whole window with itself.
            win <= {3{shreg}};
            t   <= shreg;
          end else begin
            win <= {win[1:0], shreg};
            t   <= 8'(sum >>> 2);
          end
        end
      end
    end
  end

endmodule
